// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared processor defines: fetch FSM state encoding, reset PC, halt opcode
// and the address-mask helper used by the fetch controller and PC counter.
package imem_fetch_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_HALT = 2'd3
   } fetch_state_e;

   localparam logic [15:0] DEF_RESET_PC    = 16'h0000;
   localparam logic [15:0] DEF_HALT_OPCODE = 16'hFFFF;

   // Mask keeping the low aw bits of a 16-bit address (aw=16 keeps all).
   function automatic logic [15:0] addr_mask(input int unsigned aw);
      logic [31:0] m;
      m = (32'd1 << aw) - 32'd1;
      return m[15:0];
   endfunction

endpackage

// File: rtl/imem_fetch_ctrl_pc_counter.sv
// Program counter: restart to RESET_PC, redirect to a branch target, or
// advance by one, always wrapping inside the AW-bit instruction space.
module pc_counter
   import imem_fetch_ctrl_pkg::*;
#(
   parameter int          AW       = 8,
   parameter logic [15:0] RESET_PC = DEF_RESET_PC
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        restart,
   input  logic        redirect,
   input  logic        advance,
   input  logic [15:0] target,
   output logic [15:0] pc
);

   localparam logic [15:0] PC_MASK = addr_mask(AW);

   logic [15:0] pc_d, pc_q;

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      pc_d = pc_q;
      if (restart) begin
         pc_d = RESET_PC & PC_MASK;
      end else if (redirect) begin
         pc_d = target & PC_MASK;
      end else if (advance) begin
         pc_d = (pc_q + 16'd1) & PC_MASK;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= RESET_PC & PC_MASK;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: arbitrates the instruction-memory port between
// the program loader and the fetch stage, and runs the IDLE/LOAD/RUN/HALT FSM.
module imem_fetch_ctrl
   import imem_fetch_ctrl_pkg::*;
#(
   parameter int          AW          = 8,
   parameter logic [15:0] RESET_PC    = DEF_RESET_PC,
   parameter logic [15:0] HALT_OPCODE = DEF_HALT_OPCODE
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        load_req,
   output logic        load_gnt,
   input  logic        load_we,
   input  logic [15:0] load_addr,
   input  logic [15:0] load_data,
   output logic [15:0] imem_addr,
   output logic [15:0] imem_wdata,
   output logic        imem_we,
   input  logic [15:0] imem_rdata,
   input  logic        stall,
   input  logic        branch_valid,
   input  logic [15:0] branch_target,
   output logic        if_valid,
   output logic [15:0] if_inst,
   output logic [15:0] if_pc,
   output logic        halted
);

   fetch_state_e state_d, state_q;
   logic         load_gnt_d, load_gnt_q;
   logic         if_valid_d, if_valid_q;
   logic [15:0]  if_inst_d, if_inst_q;
   logic [15:0]  if_pc_d, if_pc_q;
   logic         pc_restart, pc_redirect, pc_advance;
   logic [15:0]  pc;

   pc_counter #(
      .AW       (AW),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk      (clk),
      .rst_n    (rst_n),
      .restart  (pc_restart),
      .redirect (pc_redirect),
      .advance  (pc_advance),
      .target   (branch_target),
      .pc       (pc)
   );

   always_comb begin
      state_d     = state_q;
      if_valid_d  = 1'b0;
      if_inst_d   = if_inst_q;
      if_pc_d     = if_pc_q;
      pc_restart  = 1'b0;
      pc_redirect = 1'b0;
      pc_advance  = 1'b0;
      case (state_q)
         ST_IDLE, ST_HALT: begin
            if (load_req) begin
               state_d = ST_LOAD;
            end else if (start) begin
               state_d    = ST_RUN;
               pc_restart = 1'b1;
            end
         end
         ST_LOAD: begin
            if (!load_req) begin
               state_d    = ST_IDLE;
               pc_restart = 1'b1;
            end
         end
         ST_RUN: begin
            // A branch flushes even a stalled stage; a halt word is never issued.
            if (branch_valid) begin
               pc_redirect = 1'b1;
            end else if (stall) begin
               if_valid_d = if_valid_q;
            end else if (imem_rdata == HALT_OPCODE) begin
               state_d = ST_HALT;
            end else begin
               if_valid_d = 1'b1;
               if_inst_d  = imem_rdata;
               if_pc_d    = pc;
               pc_advance = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign load_gnt_d = (state_d == ST_LOAD);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         load_gnt_q <= 1'b0;
         if_valid_q <= 1'b0;
         if_inst_q  <= 16'h0000;
         if_pc_q    <= 16'h0000;
      end else begin
         state_q    <= state_d;
         load_gnt_q <= load_gnt_d;
         if_valid_q <= if_valid_d;
         if_inst_q  <= if_inst_d;
         if_pc_q    <= if_pc_d;
      end
   end

   // The loader only reaches the memory port while the FSM is in LOAD.
   always_comb begin
      imem_addr  = pc;
      imem_wdata = 16'h0000;
      imem_we    = 1'b0;
      if (state_q == ST_LOAD) begin
         imem_addr  = load_addr;
         imem_wdata = load_data;
         imem_we    = load_we & load_gnt_q;
      end
   end

   assign load_gnt = load_gnt_q;
   assign if_valid = if_valid_q;
   assign if_inst  = if_inst_q;
   assign if_pc    = if_pc_q;
   assign halted   = (state_q == ST_HALT);

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed program/stall/branch/wrap/reset scenarios
// followed by random traffic, all scored against a behavioural fetch model.
module tb_imem_fetch_ctrl;

   localparam logic [15:0] HALT_WORD = 16'hFFFF;
   localparam int M_IDLE = 0;
   localparam int M_LOAD = 1;
   localparam int M_RUN  = 2;
   localparam int M_HALT = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        load_req = 1'b0;
   logic        load_we = 1'b0;
   logic [15:0] load_addr = 16'h0000;
   logic [15:0] load_data = 16'h0000;
   logic        stall = 1'b0;
   logic        branch_valid = 1'b0;
   logic [15:0] branch_target = 16'h0000;
   logic        load_gnt, imem_we, if_valid, halted;
   logic [15:0] imem_addr, imem_wdata, imem_rdata, if_inst, if_pc;

   imem_fetch_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .load_req      (load_req),
      .load_gnt      (load_gnt),
      .load_we       (load_we),
      .load_addr     (load_addr),
      .load_data     (load_data),
      .imem_addr     (imem_addr),
      .imem_wdata    (imem_wdata),
      .imem_we       (imem_we),
      .imem_rdata    (imem_rdata),
      .stall         (stall),
      .branch_valid  (branch_valid),
      .branch_target (branch_target),
      .if_valid      (if_valid),
      .if_inst       (if_inst),
      .if_pc         (if_pc),
      .halted        (halted)
   );

   always #5 clk = ~clk;

   // Instruction memory seen by the DUT: 256 words, combinational read.
   logic [15:0] env_mem [256];
   assign imem_rdata = env_mem[imem_addr[7:0]];

   initial begin
      for (int i = 0; i < 256; i++) env_mem[i] = 16'h5A00 | 16'(i);
      forever begin
         @(posedge clk);
         if (imem_we) env_mem[imem_addr[7:0]] <= imem_wdata;
      end
   end

   // Reference model: program image plus architectural fetch state.
   logic [15:0] ref_mem [256];
   int          m_mode;
   logic [15:0] m_pc, m_inst, m_ifpc;
   logic        m_valid;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode  = M_IDLE;
      m_pc    = 16'h0000;
      m_inst  = 16'h0000;
      m_ifpc  = 16'h0000;
      m_valid = 1'b0;
   endtask

   // One clock: drive inputs after the falling edge, check the memory port,
   // advance the model, then check registered outputs just after the rising edge.
   task automatic cycle(input logic lr, input logic lwe, input logic [15:0] la,
                        input logic [15:0] ld, input logic st, input logic stl,
                        input logic br, input logic [15:0] bt);
      logic [15:0] word;
      @(negedge clk);
      load_req = lr; load_we = lwe; load_addr = la; load_data = ld;
      start = st; stall = stl; branch_valid = br; branch_target = bt;
      #1;
      check("imem_addr", 32'(imem_addr), 32'((m_mode == M_LOAD) ? la : m_pc));
      check("imem_we", 32'(imem_we), 32'((m_mode == M_LOAD) && lwe));
      case (m_mode)
         M_IDLE, M_HALT: begin
            m_valid = 1'b0;
            if (lr) m_mode = M_LOAD;
            else if (st) begin
               m_mode = M_RUN;
               m_pc   = 16'h0000;
            end
         end
         M_LOAD: begin
            m_valid = 1'b0;
            if (lwe) ref_mem[la[7:0]] = ld;
            if (!lr) begin
               m_mode = M_IDLE;
               m_pc   = 16'h0000;
            end
         end
         default: begin
            if (br) begin
               m_pc    = bt & 16'h00FF;
               m_valid = 1'b0;
            end else if (!stl) begin
               word = ref_mem[m_pc[7:0]];
               if (word == HALT_WORD) begin
                  m_mode  = M_HALT;
                  m_valid = 1'b0;
               end else begin
                  m_valid = 1'b1;
                  m_inst  = word;
                  m_ifpc  = m_pc;
                  m_pc    = (m_pc + 16'd1) & 16'h00FF;
               end
            end
         end
      endcase
      @(posedge clk);
      #1;
      check("load_gnt", 32'(load_gnt), 32'(m_mode == M_LOAD));
      check("halted", 32'(halted), 32'(m_mode == M_HALT));
      check("if_valid", 32'(if_valid), 32'(m_valid));
      check("if_inst", 32'(if_inst), 32'(m_inst));
      check("if_pc", 32'(if_pc), 32'(m_ifpc));
   endtask

   task automatic idle_cycle();
      cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
   endtask

   task automatic load_word(input logic [15:0] a, input logic [15:0] d);
      cycle(1'b1, 1'b1, a, d, 1'b0, 1'b0, 1'b0, 16'h0000);
   endtask

   initial begin
      logic lr, lwe, st, stl, br;
      logic [15:0] la, ld, bt;

      for (int i = 0; i < 256; i++) ref_mem[i] = 16'h5A00 | 16'(i);
      model_reset();

      // Reset state, asserted from time zero.
      #1;
      check("rst_if_valid", 32'(if_valid), 32'h0);
      check("rst_if_inst", 32'(if_inst), 32'h0);
      check("rst_if_pc", 32'(if_pc), 32'h0);
      check("rst_load_gnt", 32'(load_gnt), 32'h0);
      check("rst_halted", 32'(halted), 32'h0);
      check("rst_imem_we", 32'(imem_we), 32'h0);
      check("rst_pc", 32'(imem_addr), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Load a three-word program ending in the halt opcode, then run it.
      cycle(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
      check("gnt_first_load", 32'(load_gnt), 32'h1);
      load_word(16'h0000, 16'h0A29);
      load_word(16'h0001, 16'h0629);
      load_word(16'h0002, 16'hFFFF);
      idle_cycle();
      check("load_exit_gnt", 32'(load_gnt), 32'h0);
      cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000);
      idle_cycle();
      check("prog_inst0", 32'(if_inst), 32'h0A29);
      check("prog_valid0", 32'(if_valid), 32'h1);
      idle_cycle();
      check("prog_inst1", 32'(if_inst), 32'h0629);
      check("prog_pc1", 32'(if_pc), 32'h1);
      idle_cycle();
      check("prog_halted", 32'(halted), 32'h1);
      check("prog_halt_valid", 32'(if_valid), 32'h0);

      // Loader request during RUN is held off until HALT.
      cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
         check("run_no_gnt", 32'(load_gnt), 32'h0);
      end
      check("run_req_halted", 32'(halted), 32'h1);
      cycle(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
      check("halt_then_gnt", 32'(load_gnt), 32'h1);

      // Reset in the middle of a load write.
      @(negedge clk);
      load_req = 1'b1; load_we = 1'b1; load_addr = 16'h0005; load_data = 16'h1234;
      #1;
      check("pre_rst_we", 32'(imem_we), 32'h1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_we", 32'(imem_we), 32'h0);
      check("mid_rst_gnt", 32'(load_gnt), 32'h0);
      check("mid_rst_addr", 32'(imem_addr), 32'h0);
      @(posedge clk);
      #1;
      check("mid_rst_nowrite", 32'(env_mem[5]), 32'h5A05);
      @(negedge clk);
      rst_n = 1'b1;
      load_req = 1'b0; load_we = 1'b0; load_addr = 16'h0000; load_data = 16'h0000;
      model_reset();

      // Stall for three cycles with pc=1, then resume.
      cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000);
      idle_cycle();
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000);
         check("stall_pc", 32'(if_pc), 32'h0);
         check("stall_inst", 32'(if_inst), 32'h0A29);
      end
      idle_cycle();
      check("resume_pc", 32'(if_pc), 32'h1);
      check("resume_addr", 32'(imem_addr), 32'h2);

      // Branch beats stall: one flushed cycle, then fetch from the target.
      cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0010);
      check("branch_flush", 32'(if_valid), 32'h0);
      idle_cycle();
      check("branch_pc", 32'(if_pc), 32'h10);
      check("branch_inst", 32'(if_inst), 32'h5A10);

      // Target bits above AW are dropped; pc wraps 0xFF -> 0x00.
      cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h12FE);
      check("branch_mask", 32'(imem_addr), 32'hFE);
      idle_cycle();
      idle_cycle();
      check("wrap_ff", 32'(if_pc), 32'hFF);
      idle_cycle();
      check("wrap_00", 32'(if_pc), 32'h0);
      check("wrap_inst", 32'(if_inst), 32'h0A29);

      // Random traffic.
      for (int i = 0; i < 4000; i++) begin
         lr  = ($urandom_range(0, 9) < 2);
         lwe = ($urandom_range(0, 1) == 1);
         la  = 16'($urandom);
         ld  = ($urandom_range(0, 7) == 0) ? HALT_WORD : 16'($urandom);
         st  = ($urandom_range(0, 2) == 0);
         stl = ($urandom_range(0, 3) == 0);
         br  = ($urandom_range(0, 9) == 0);
         bt  = 16'($urandom);
         cycle(lr, lwe, la, ld, st, stl, br, bt);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
